irq_pending_ctrl: RTL and testbench
===================================

// Module: irq_pending_ctrl
// PURPOSE
//   Interrupt front-end that sits directly around the 4-input priority_encoder.
//   - Edge-captures request lines into a pending register and applies an enable mask.
//   - Drives the encoder's `in` with the pending & enabled bits.
//   - Takes the encoder's `out`/`valid` and runs an irq/ack handshake towards the CPU.
//   - Clears the serviced pending bit on acknowledge.
// PARAMETERS
//   N_SRC        4    number of request sources; must equal the encoder input width
//   ID_W         2    source-id width; log2(N_SRC), must equal the encoder output width
//   ACK_TIMEOUT  15   cycles irq may stay up without ack before it is withdrawn (>=2)
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   req_in     in   N_SRC  request lines, synchronous to clk; rising edge = new request
//   irq_en     in   N_SRC  per-source enable mask (1 = enabled), level
//   enc_in     out  N_SRC  to priority_encoder.in: pending & irq_en (combinational)
//   enc_out    in   ID_W   from priority_encoder.out: highest set bit index
//   enc_valid  in   1      from priority_encoder.valid: any bit of enc_in set
//   irq        out  1      interrupt request to CPU, registered
//   irq_id     out  ID_W   source id being serviced, registered, stable while irq=1
//   irq_ack    in   1      CPU acknowledge, one-cycle pulse, honoured only while irq=1
//   overrun    out  1      1-cycle pulse: new edge on a source already pending (registered)
//   timeout    out  1      1-cycle pulse: irq withdrawn after ACK_TIMEOUT cycles (registered)
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//   - Cleared: req_q, pending, irq, irq_id, overrun, timeout, wait counter.
//   - State goes to IDLE.
//   - req_q resets to 0, so a request already high when rst releases counts as an edge.
//   - A reset mid-handshake drops irq on the next edge; no pending bit survives.
//   Edge capture:
//   - edge[i] = req_in[i] & ~req_q[i]; req_q <= req_in every cycle.
//   - pending[i] <= 1 on edge[i], regardless of irq_en. Masking only gates enc_in.
//   - Pending bits of masked sources are retained.
//   - Set wins over clear: if edge[i] coincides with an ack clearing bit i, bit i stays 1.
//   - overrun pulses for one cycle when edge[i] & pending[i] for any i.
//     The request merges and is not counted.
//   Encoder interface:
//   - enc_in = pending & irq_en, purely combinational; no register in the loop.
//   FSM: IDLE -> ASSERT -> HOLD -> IDLE
//   - IDLE: if enc_valid, then irq_id <= enc_out, irq <= 1, counter <= 0, go ASSERT.
//   - ASSERT: irq=1, irq_id frozen. Mask or pending changes do not alter irq_id.
//     - irq_ack=1: pending[irq_id] <= 0 (subject to set-wins), irq <= 0, go HOLD.
//     - Else, counter == ACK_TIMEOUT-1: irq <= 0, timeout pulse, go HOLD.
//       pending[irq_id] is retained.
//     - Else: counter increments.
//   - HOLD: one idle cycle so the encoder sees the updated pending; go IDLE.
//   - irq_ack outside ASSERT is ignored. Ack and timeout in the same cycle: ack wins.
//   Latency:
//   - req_in rises at sampling edge k: pending visible after k, irq=1 after edge k+1.
//     That is 2 cycles, when IDLE and the source is highest enabled.
//   - Back-to-back service: ack at edge a; next irq rises after edge a+2.
//   Width rules: irq_id is a direct copy of enc_out; the counter is $clog2(ACK_TIMEOUT) bits, with no wrap.
// TESTING
//   1. Reset, irq_en=4'b1111; pulse req_in[2]: enc_in=4'b0100, irq=1 with irq_id=2 two cycles later;
//      ack -> pending=0, irq=0, HOLD, then IDLE.
//   2. req_in=4'b0110 same cycle: irq_id=2 first; ack -> irq_id=1 two cycles later; ack -> all pending=0.
//   3. irq_en=4'b0111, req_in[3] edge: enc_in=0, irq stays 0;
//      set irq_en[3]=1 -> irq with irq_id=3 after next edge.
//   4. No ack for ACK_TIMEOUT=15 cycles: irq drops, timeout pulses once;
//      pending[id] still 1, and irq re-asserts with the same id 2 cycles later.
//   5. While pending[0]=1, re-pulse req_in[0]: overrun=1 for one cycle.
//      Edge on bit 1 in the same cycle as the ack of id 1: pending[1] stays 1.
//   6. Assert rst while irq=1: irq=0, pending=0 next cycle; req_in held high through reset
//      -> re-captured as an edge after release.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end around a priority encoder: edge-captured pending bits, enable masking, irq/ack handshake.
// Latency: request edge to irq in 2 cycles when idle; an ack frees the next irq 2 cycles later. No backpressure: requests merge into pending.
module irq_pending_ctrl #(
   parameter int N_SRC       = 4,
   parameter int ID_W        = 2,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] req_in,
   input  logic [N_SRC-1:0] irq_en,
   output logic [N_SRC-1:0] enc_in,
   input  logic [ID_W-1:0]  enc_out,
   input  logic             enc_valid,
   output logic             irq,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack,
   output logic             overrun,
   output logic             timeout
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t           state;
   logic [N_SRC-1:0] req_q;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] edges;
   logic [N_SRC-1:0] clr;
   logic [CNT_W-1:0] wait_cnt;

   assign edges  = req_in & ~req_q;
   assign enc_in = pending & irq_en;

   // Only an ack taken while the irq is actually up retires a source.
   always_comb begin
      clr = '0;
      if (state == ASSERT && irq_ack) begin
         clr[irq_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         req_q    <= '0;
         pending  <= '0;
         irq      <= 1'b0;
         irq_id   <= '0;
         overrun  <= 1'b0;
         timeout  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         req_q   <= req_in;
         // A fresh edge beats a same-cycle clear so no request is lost.
         pending <= (pending & ~clr) | edges;
         overrun <= |(edges & pending);
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (enc_valid) begin
                  irq_id   <= enc_out;
                  irq      <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ASSERT;
               end
            end
            ASSERT: begin
               if (irq_ack) begin
                  irq   <= 1'b0;
                  state <= HOLD;
               end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                  irq     <= 1'b0;
                  timeout <= 1'b1;
                  state   <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            HOLD: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed vector table, hand sequences and random traffic against a reference model.
module tb_irq_pending_ctrl;
   localparam int N_SRC = 4;
   localparam int ID_W  = 2;
   localparam int TMO   = 15;

   logic             clk;
   logic             rst;
   logic [N_SRC-1:0] req_in;
   logic [N_SRC-1:0] irq_en;
   logic [N_SRC-1:0] enc_in;
   logic [ID_W-1:0]  enc_out;
   logic             enc_valid;
   logic             irq;
   logic [ID_W-1:0]  irq_id;
   logic             irq_ack;
   logic             overrun;
   logic             timeout;

   int n_vec = 0;
   int n_err = 0;

   irq_pending_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .irq_en(irq_en), .enc_in(enc_in),
      .enc_out(enc_out), .enc_valid(enc_valid), .irq(irq), .irq_id(irq_id),
      .irq_ack(irq_ack), .overrun(overrun), .timeout(timeout)
   );

   // External priority encoder: index of the highest set bit.
   always_comb begin
      enc_valid = |enc_in;
      enc_out   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (enc_in[i]) enc_out = ID_W'(i);
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending set, service slot with age, one-cycle gap after service.
   bit [N_SRC-1:0] m_pend, m_req_q;
   bit             m_irq, m_gap, m_ovr, m_tmo;
   int             m_id, m_age;

   task automatic model_tick();
      bit [N_SRC-1:0] edg;
      int             hi;
      edg   = req_in & ~m_req_q;
      m_tmo = 0;
      if (rst) begin
         m_pend = '0; m_req_q = '0; m_irq = 0; m_gap = 0; m_ovr = 0; m_id = 0; m_age = 0;
         return;
      end
      m_ovr = 0;
      for (int i = 0; i < N_SRC; i++) if (edg[i] && m_pend[i]) m_ovr = 1;
      if (m_irq) begin
         if (irq_ack) begin
            m_pend[m_id] = 0;
            m_irq = 0; m_gap = 1;
         end else if (m_age + 1 == TMO) begin
            m_irq = 0; m_gap = 1; m_tmo = 1;
         end else begin
            m_age++;
         end
      end else if (m_gap) begin
         m_gap = 0;
      end else begin
         hi = -1;
         for (int i = 0; i < N_SRC; i++) if (m_pend[i] && irq_en[i]) hi = i;
         if (hi >= 0) begin
            m_irq = 1; m_id = hi; m_age = 0;
         end
      end
      m_pend  = m_pend | edg;
      m_req_q = req_in;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("m_irq", 32'(irq), 32'(m_irq));
      check("m_ovr", 32'(overrun), 32'(m_ovr));
      check("m_tmo", 32'(timeout), 32'(m_tmo));
      check("m_enc", 32'(enc_in), 32'(m_pend & irq_en));
      if (m_irq) check("m_id", 32'(irq_id), 32'(m_id));
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] en, input logic ak);
      rst = r; req_in = rq; irq_en = en; irq_ack = ak;
      @(posedge clk);
      model_tick();
      #1;
      check_model();
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] en;
      logic       ack;
      logic       x_irq;
      logic [1:0] x_id;
      logic       x_ovr;
      logic       x_tmo;
      logic [3:0] x_enc;
   } vec_t;

   vec_t vt [29];

   initial begin
      //          rst  req     en      ack   irq  id     ovr  tmo  enc
      vt[0]  = '{1'b1, 4'h0, 4'hf, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
      vt[1]  = '{1'b0, 4'h4, 4'hf, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h4};
      vt[2]  = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h4};
      vt[3]  = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'h0};
      vt[4]  = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'h0};
      vt[5]  = '{1'b0, 4'h6, 4'hf, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'h6};
      vt[6]  = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h6};
      vt[7]  = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 4'h2};
      vt[8]  = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 4'h2};
      vt[9]  = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2};
      vt[10] = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};
      vt[11] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};
      vt[12] = '{1'b0, 4'h8, 4'h7, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};
      vt[13] = '{1'b0, 4'h0, 4'h7, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};
      vt[14] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'h8};
      vt[15] = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 4'h0};
      vt[16] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h0};
      vt[17] = '{1'b0, 4'h1, 4'hf, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'h1};
      vt[18] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h1};
      vt[19] = '{1'b0, 4'h1, 4'hf, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'h1};
      vt[20] = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
      vt[21] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0};
      vt[22] = '{1'b0, 4'h2, 4'hf, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h2};
      vt[23] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2};
      vt[24] = '{1'b0, 4'h2, 4'hf, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 4'h2};
      vt[25] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h2};
      vt[26] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2};
      vt[27] = '{1'b0, 4'h0, 4'hf, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};
      vt[28] = '{1'b0, 4'h0, 4'hf, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'h0};

      rst = 1'b1; req_in = '0; irq_en = 4'hf; irq_ack = 1'b0;
      m_pend = '0; m_req_q = '0; m_irq = 0; m_gap = 0; m_ovr = 0; m_tmo = 0; m_id = 0; m_age = 0;
      @(negedge clk);

      for (int v = 0; v < 29; v++) begin
         step(vt[v].rst, vt[v].req, vt[v].en, vt[v].ack);
         check($sformatf("v%0d_irq", v), 32'(irq), 32'(vt[v].x_irq));
         check($sformatf("v%0d_ovr", v), 32'(overrun), 32'(vt[v].x_ovr));
         check($sformatf("v%0d_tmo", v), 32'(timeout), 32'(vt[v].x_tmo));
         check($sformatf("v%0d_enc", v), 32'(enc_in), 32'(vt[v].x_enc));
         if (vt[v].x_irq) check($sformatf("v%0d_id", v), 32'(irq_id), 32'(vt[v].x_id));
      end

      // Timeout: irq stays up exactly TMO cycles, pending kept, re-asserts 2 cycles later.
      step(0, 4'h8, 4'hf, 0);
      step(0, 4'h0, 4'hf, 0);
      check("tmo_rise", 32'(irq), 32'd1);
      for (int i = 0; i < TMO - 1; i++) begin
         step(0, 4'h0, 4'hf, 0);
         check("tmo_hold_irq", 32'(irq), 32'd1);
         check("tmo_hold_pulse", 32'(timeout), 32'd0);
      end
      step(0, 4'h0, 4'hf, 0);
      check("tmo_drop", 32'(irq), 32'd0);
      check("tmo_pulse", 32'(timeout), 32'd1);
      check("tmo_pend", 32'(enc_in), 32'h8);
      step(0, 4'h0, 4'hf, 0);
      check("tmo_once", 32'(timeout), 32'd0);
      check("tmo_gap", 32'(irq), 32'd0);
      step(0, 4'h0, 4'hf, 0);
      check("tmo_reirq", 32'(irq), 32'd1);
      check("tmo_reid", 32'(irq_id), 32'd3);
      step(0, 4'h0, 4'hf, 1);
      step(0, 4'h0, 4'hf, 0);

      // Reset mid-handshake with a request held high through reset.
      step(0, 4'h2, 4'hf, 0);
      step(0, 4'h2, 4'hf, 0);
      check("rst_pre_irq", 32'(irq), 32'd1);
      step(1, 4'h2, 4'hf, 0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_pend", 32'(enc_in), 32'h0);
      step(1, 4'h2, 4'hf, 0);
      step(0, 4'h2, 4'hf, 0);
      check("rst_recapture", 32'(enc_in), 32'h2);
      step(0, 4'h2, 4'hf, 0);
      check("rst_reirq", 32'(irq), 32'd1);
      check("rst_reid", 32'(irq_id), 32'd1);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] rq, en;
         rq = 4'($urandom);
         en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : irq_en;
         step(($urandom_range(0, 199) == 0), rq, en, ($urandom_range(0, 9) < 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
